// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store byte-enable generator:
//   - store size encodings as carried on req_size
//   - beat sequencer state enum
//   - size_bytes(): number of bytes a size encoding covers
// -----------------------------------------------------------------------------
package store_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_e;

    // 1, 2, 4 or 8 bytes.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/be_lane_shift.sv
// -----------------------------------------------------------------------------
// be_lane_shift
// Combinational lane alignment for one store request. The result spans two
// bus words so a store that runs past the end of its bus word can be issued
// as two aligned beats: the low half is beat 0, the high half is beat 1.
//
// Ports:
//   off_i    byte offset of the store inside its bus word
//   size_i   size encoding (byte/half/word/dword)
//   wdata_i  right-justified store data
//   mask_o   byte-enable mask over two bus words
//   data_o   lane-shifted data over two bus words, disabled lanes forced to 0
//   cross_o  store touches the second bus word (needs beat 1)
//   err_o    store must be trapped (illegal size, or misaligned in mode 0)
// -----------------------------------------------------------------------------
module be_lane_shift
    import store_pkg::*;
#(
    parameter int   DATA_W        = 32,
    parameter int   MISALIGN_MODE = 0,
    localparam int  NB            = DATA_W / 8,
    localparam int  OFF_W         = $clog2(NB)
) (
    input  logic [OFF_W-1:0]    off_i,
    input  logic [1:0]          size_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [2*NB-1:0]     mask_o,
    output logic [2*DATA_W-1:0] data_o,
    output logic                cross_o,
    output logic                err_o
);

    localparam int MW  = 2 * NB;
    localparam int DW2 = 2 * DATA_W;

    logic [3:0]     szb;
    logic [MW-1:0]  base_mask;
    logic [DW2-1:0] shifted;
    logic [3:0]     off_ext;
    logic           misalign;
    logic           illegal_size;

    always_comb begin
        szb          = size_bytes(size_i);
        base_mask    = MW'((16'd1 << szb) - 16'd1);
        mask_o       = base_mask << off_i;
        shifted      = DW2'(wdata_i) << {off_i, 3'b000};
        // Natural alignment: offset must be a multiple of the access size.
        off_ext      = 4'(off_i);
        misalign     = (off_ext & (szb - 4'd1)) != 4'd0;
        illegal_size = (DATA_W == 32) && (size_i == SZ_DWORD);
        err_o        = illegal_size || ((MISALIGN_MODE == 0) && misalign);
        cross_o      = (|mask_o[MW-1:NB]) && !err_o;
    end

    // Zero every lane the mask does not enable, so upper garbage in a
    // right-justified narrow store never reaches the bus.
    genvar gi;
    generate
        for (gi = 0; gi < MW; gi++) begin : g_lane
            assign data_o[gi*8 +: 8] = mask_o[gi] ? shifted[gi*8 +: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/store_be_gen.sv
// -----------------------------------------------------------------------------
// store_be_gen
// Turns one store request into one or two registered bus write beats with
// lane-aligned data and byte enables. Misaligned stores are trapped
// (MISALIGN_MODE=0) or, when they cross a bus word, split into two beats
// (MISALIGN_MODE=1). DATA_W must be 32 or 64.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   store request handshake
//   req_addr/size/wdata   byte address, size encoding, right-justified data
//   bus_valid/bus_ready   write beat handshake
//   bus_addr/be/wdata     aligned beat address, byte enables, lane data
//   bus_last              final beat of the current request
//   align_err             one-cycle pulse after an erroring request is accepted
// -----------------------------------------------------------------------------
module store_be_gen
    import store_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 32,
    parameter int MISALIGN_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic                bus_last,
    output logic                align_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    // Lane alignment of the incoming request
    logic [2*NB-1:0]     lane_mask;
    logic [2*DATA_W-1:0] lane_data;
    logic                lane_cross;
    logic                lane_err;

    be_lane_shift #(
        .DATA_W        (DATA_W),
        .MISALIGN_MODE (MISALIGN_MODE)
    ) u_lane_shift (
        .off_i   (req_addr[OFF_W-1:0]),
        .size_i  (req_size),
        .wdata_i (req_wdata),
        .mask_o  (lane_mask),
        .data_o  (lane_data),
        .cross_o (lane_cross),
        .err_o   (lane_err)
    );

    // State, output registers and beat-1 holding registers
    state_e              state_q, state_d;
    logic                bus_valid_q, bus_valid_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [NB-1:0]       bus_be_q, bus_be_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                bus_last_q, bus_last_d;
    logic                align_err_q, align_err_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [NB-1:0]       hold_be_q, hold_be_d;
    logic [DATA_W-1:0]   hold_wdata_q, hold_wdata_d;

    logic                accept;
    logic                consume;
    logic [ADDR_W-1:0]   addr0;
    logic [ADDR_W-1:0]   addr1;

    always_comb begin
        consume   = bus_valid_q && bus_ready;
        // A new request may land in the same edge the last beat leaves.
        req_ready = (state_q == ST_IDLE) || (consume && bus_last_q);
        accept    = req_valid && req_ready;
        addr0     = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        addr1     = addr0 + ADDR_W'(NB);   // wraps modulo 2^ADDR_W
    end

    always_comb begin
        state_d      = state_q;
        bus_valid_d  = bus_valid_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        bus_last_d   = bus_last_q;
        align_err_d  = 1'b0;
        hold_addr_d  = hold_addr_q;
        hold_be_d    = hold_be_q;
        hold_wdata_d = hold_wdata_q;

        unique case (state_q)
            ST_IDLE: ;
            ST_BEAT0: begin
                if (consume) begin
                    if (!bus_last_q) begin
                        // Not last in beat 0 means the store crosses a word.
                        state_d     = ST_BEAT1;
                        bus_addr_d  = hold_addr_q;
                        bus_be_d    = hold_be_q;
                        bus_wdata_d = hold_wdata_q;
                        bus_last_d  = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        bus_valid_d = 1'b0;
                        bus_be_d    = '0;
                        bus_wdata_d = '0;
                        bus_last_d  = 1'b0;
                    end
                end
            end
            ST_BEAT1: begin
                if (consume) begin
                    state_d     = ST_IDLE;
                    bus_valid_d = 1'b0;
                    bus_be_d    = '0;
                    bus_wdata_d = '0;
                    bus_last_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Acceptance overrides the drain decision above (back-to-back case).
        if (accept) begin
            if (lane_err) begin
                state_d     = ST_IDLE;
                align_err_d = 1'b1;
                bus_valid_d = 1'b0;
                bus_be_d    = '0;
                bus_wdata_d = '0;
                bus_last_d  = 1'b0;
            end else begin
                state_d      = ST_BEAT0;
                bus_valid_d  = 1'b1;
                bus_addr_d   = addr0;
                bus_be_d     = lane_mask[NB-1:0];
                bus_wdata_d  = lane_data[DATA_W-1:0];
                bus_last_d   = !lane_cross;
                hold_addr_d  = addr1;
                hold_be_d    = lane_mask[2*NB-1:NB];
                hold_wdata_d = lane_data[2*DATA_W-1:DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bus_valid_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            bus_last_q   <= 1'b0;
            align_err_q  <= 1'b0;
            hold_addr_q  <= '0;
            hold_be_q    <= '0;
            hold_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            bus_valid_q  <= bus_valid_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_last_q   <= bus_last_d;
            align_err_q  <= align_err_d;
            hold_addr_q  <= hold_addr_d;
            hold_be_q    <= hold_be_d;
            hold_wdata_q <= hold_wdata_d;
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_last  = bus_last_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_store_be_gen.sv
// -----------------------------------------------------------------------------
// tb_store_be_gen
// Three instances share clk/rst_n:
//   idx 0: DATA_W=32, mode 0    idx 1: DATA_W=32, mode 1    idx 2: DATA_W=64, mode 1
// Expected beats come from a byte-by-byte reference model.
// -----------------------------------------------------------------------------
module tb_store_be_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid [3];
    logic [31:0] req_addr  [3];
    logic [1:0]  req_size  [3];
    logic [63:0] req_wdata [3];
    logic        bus_ready [3];

    logic        req_ready_w [3];
    logic        bus_valid_w [3];
    logic [31:0] bus_addr_w  [3];
    logic [7:0]  bus_be_w    [3];
    logic [63:0] bus_wdata_w [3];
    logic        bus_last_w  [3];
    logic        align_err_w [3];

    logic [3:0]  be_0, be_1;
    logic [31:0] wd_0, wd_1;
    assign bus_be_w[0]    = {4'h0, be_0};
    assign bus_be_w[1]    = {4'h0, be_1};
    assign bus_wdata_w[0] = {32'h0, wd_0};
    assign bus_wdata_w[1] = {32'h0, wd_1};

    store_be_gen #(.DATA_W(32), .ADDR_W(32), .MISALIGN_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready_w[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0][31:0]),
        .bus_valid(bus_valid_w[0]), .bus_ready(bus_ready[0]),
        .bus_addr(bus_addr_w[0]), .bus_be(be_0), .bus_wdata(wd_0),
        .bus_last(bus_last_w[0]), .align_err(align_err_w[0]));

    store_be_gen #(.DATA_W(32), .ADDR_W(32), .MISALIGN_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready_w[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1][31:0]),
        .bus_valid(bus_valid_w[1]), .bus_ready(bus_ready[1]),
        .bus_addr(bus_addr_w[1]), .bus_be(be_1), .bus_wdata(wd_1),
        .bus_last(bus_last_w[1]), .align_err(align_err_w[1]));

    store_be_gen #(.DATA_W(64), .ADDR_W(32), .MISALIGN_MODE(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[2]), .req_ready(req_ready_w[2]),
        .req_addr(req_addr[2]), .req_size(req_size[2]), .req_wdata(req_wdata[2]),
        .bus_valid(bus_valid_w[2]), .bus_ready(bus_ready[2]),
        .bus_addr(bus_addr_w[2]), .bus_be(bus_be_w[2]), .bus_wdata(bus_wdata_w[2]),
        .bus_last(bus_last_w[2]), .align_err(align_err_w[2]));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model results
    logic        exp_err;
    int          exp_n;
    logic [31:0] exp_addr [2];
    logic [7:0]  exp_be   [2];
    logic [63:0] exp_wd   [2];
    logic        exp_last [2];

    // Observed beats from xfer
    int          obs_n;
    int          obs_err;
    logic [31:0] obs_addr [2];
    logic [7:0]  obs_be   [2];
    logic [63:0] obs_wd   [2];
    logic        obs_last [2];

    // Place each store byte k at absolute byte (off + k) of a two-word window.
    task automatic model(input int idx, input logic [31:0] a, input logic [1:0] s,
                         input logic [63:0] d);
        int nb, mode, off, sz, b, beat, lane;
        logic [31:0] base;
        nb   = (idx == 2) ? 8 : 4;
        mode = (idx == 0) ? 0 : 1;
        off  = int'(a % nb);
        sz   = 1 << s;
        exp_err = (s == 2'd3 && nb == 4) || (mode == 0 && (off % sz) != 0);
        exp_n = 0;
        for (int i = 0; i < 2; i++) begin
            exp_addr[i] = '0; exp_be[i] = '0; exp_wd[i] = '0; exp_last[i] = 1'b0;
        end
        if (!exp_err) begin
            base = a - 32'(off);
            for (int k = 0; k < sz; k++) begin
                b    = off + k;
                beat = b / nb;
                lane = b % nb;
                exp_be[beat][lane] = 1'b1;
                exp_wd[beat][lane*8 +: 8] = d[k*8 +: 8];
                if (beat + 1 > exp_n) exp_n = beat + 1;
            end
            for (int i = 0; i < exp_n; i++) begin
                exp_addr[i] = base + 32'(i * nb);
                exp_last[i] = (i == exp_n - 1);
            end
        end
    endtask

    // Drive one request and record what the bus does with it (no checking).
    task automatic xfer(input int idx, input logic [31:0] a, input logic [1:0] s,
                        input logic [63:0] d, input bit rnd_ready);
        int guard;
        bit fin;
        req_valid[idx] = 1'b1; req_addr[idx] = a; req_size[idx] = s; req_wdata[idx] = d;
        guard = 0;
        while (!req_ready_w[idx] && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        obs_n = 0; obs_err = 0;
        for (int i = 0; i < 2; i++) begin
            obs_addr[i] = '0; obs_be[i] = '0; obs_wd[i] = '0; obs_last[i] = 1'b0;
        end
        for (int c = 0; c < 60; c++) begin
            bus_ready[idx] = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (align_err_w[idx]) obs_err++;
            fin = 1'b0;
            if (bus_valid_w[idx] && bus_ready[idx]) begin
                if (obs_n < 2) begin
                    obs_addr[obs_n] = bus_addr_w[idx];
                    obs_be[obs_n]   = bus_be_w[idx];
                    obs_wd[obs_n]   = bus_wdata_w[idx];
                    obs_last[obs_n] = bus_last_w[idx];
                end
                obs_n++;
                if (bus_last_w[idx]) fin = 1'b1;
            end else if (c >= 1 && !bus_valid_w[idx] && obs_n == 0) begin
                fin = 1'b1;
            end
            @(posedge clk); #1;
            if (fin) break;
        end
        bus_ready[idx] = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({bus_valid_w[i], bus_addr_w[i], bus_be_w[i], bus_wdata_w[i], bus_last_w[i],
                 align_err_w[i], req_ready_w[i]} !== {1'b0, 32'h0, 8'h0, 64'h0, 1'b0, 1'b0, 1'b1})
                begin
                n_fail++;
                $display("FAIL reset inst%0d: valid=%b addr=%h be=%h wd=%h last=%b err=%b rdy=%b, required all 0 and rdy=1",
                         i, bus_valid_w[i], bus_addr_w[i], bus_be_w[i], bus_wdata_w[i],
                         bus_last_w[i], align_err_w[i], req_ready_w[i]);
            end
        end
        $display("reset check done");
    endtask

    task automatic test_aligned();
        logic [31:0] a_t [3] = '{32'h1000, 32'h1003, 32'h1002};
        logic [1:0]  s_t [3] = '{2'd2, 2'd0, 2'd1};
        logic [63:0] d_t [3] = '{64'hDEADBEEF, 64'hFFFFFF5A, 64'hABCD1234};
        logic [3:0]  be_t[3] = '{4'hF, 4'h8, 4'hC};
        logic [31:0] wd_t[3] = '{32'hDEADBEEF, 32'h5A000000, 32'h12340000};
        for (int i = 0; i < 3; i++) begin
            xfer(0, a_t[i], s_t[i], d_t[i], 1'b0);
            n_checks++;
            if ({obs_n, obs_err, obs_addr[0], obs_be[0], obs_wd[0], obs_last[0]} !==
                {32'd1, 32'd0, 32'h1000, {4'h0, be_t[i]}, {32'h0, wd_t[i]}, 1'b1}) begin
                n_fail++;
                $display("FAIL aligned%0d: n=%0d err=%0d addr=%h be=%h wd=%h last=%b, required n=1 addr=00001000 be=%h wd=%h last=1",
                         i, obs_n, obs_err, obs_addr[0], obs_be[0], obs_wd[0], obs_last[0],
                         be_t[i], wd_t[i]);
            end
            $display("aligned store addr=%h size=%0d be=%h wd=%h", a_t[i], s_t[i], obs_be[0], obs_wd[0]);
        end
    endtask

    task automatic test_split();
        xfer(1, 32'h1002, 2'd2, 64'hAABBCCDD, 1'b0);
        n_checks++;
        if ({obs_n, obs_err} !== {32'd2, 32'd0}) begin
            n_fail++;
            $display("FAIL split count: beats=%0d err=%0d, required beats=2 err=0", obs_n, obs_err);
        end
        n_checks++;
        if ({obs_addr[0], obs_be[0], obs_wd[0], obs_last[0]} !==
            {32'h1000, 8'h0C, 64'hCCDD0000, 1'b0}) begin
            n_fail++;
            $display("FAIL split beat0: addr=%h be=%h wd=%h last=%b, required 00001000 0c ccdd0000 0",
                     obs_addr[0], obs_be[0], obs_wd[0], obs_last[0]);
        end
        n_checks++;
        if ({obs_addr[1], obs_be[1], obs_wd[1], obs_last[1]} !==
            {32'h1004, 8'h03, 64'h0000AABB, 1'b1}) begin
            n_fail++;
            $display("FAIL split beat1: addr=%h be=%h wd=%h last=%b, required 00001004 03 0000aabb 1",
                     obs_addr[1], obs_be[1], obs_wd[1], obs_last[1]);
        end
        $display("split store beats=%0d be0=%h be1=%h", obs_n, obs_be[0], obs_be[1]);
    endtask

    task automatic test_align_err();
        // Mode 0 misaligned word, then a good store right in the error cycle.
        req_valid[0] = 1'b1; req_addr[0] = 32'h1002; req_size[0] = 2'd2; req_wdata[0] = 64'hAABBCCDD;
        @(posedge clk); #1;
        n_checks++;
        if ({align_err_w[0], bus_valid_w[0], req_ready_w[0]} !== 3'b101) begin
            n_fail++;
            $display("FAIL mode0 err pulse: err=%b valid=%b rdy=%b, required err=1 valid=0 rdy=1",
                     align_err_w[0], bus_valid_w[0], req_ready_w[0]);
        end
        req_addr[0] = 32'h1000; req_wdata[0] = 64'h01020304;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n_checks++;
        if ({align_err_w[0], bus_valid_w[0], bus_be_w[0], bus_wdata_w[0]} !==
            {1'b0, 1'b1, 8'h0F, 64'h01020304}) begin
            n_fail++;
            $display("FAIL mode0 after err: err=%b valid=%b be=%h wd=%h, required err=0 valid=1 be=0f wd=01020304",
                     align_err_w[0], bus_valid_w[0], bus_be_w[0], bus_wdata_w[0]);
        end
        @(posedge clk); #1;
        $display("mode0 misaligned store trapped, next store accepted");
        // Illegal dword on a 32-bit bus in mode 1.
        xfer(1, 32'h2000, 2'd3, 64'h1122334455667788, 1'b0);
        n_checks++;
        if ({obs_err, obs_n} !== {32'd1, 32'd0}) begin
            n_fail++;
            $display("FAIL illegal size: err cycles=%0d beats=%0d, required 1 and 0", obs_err, obs_n);
        end
        $display("illegal dword on 32-bit bus err=%0d beats=%0d", obs_err, obs_n);
    endtask

    task automatic test_backpressure();
        logic [31:0] sa; logic [7:0] sb; logic [63:0] sw; logic sl;
        logic [63:0] d;
        d = {32'h0, $urandom};
        model(1, 32'h2002, 2'd2, d);
        bus_ready[1] = 1'b0;
        req_valid[1] = 1'b1; req_addr[1] = 32'h2002; req_size[1] = 2'd2; req_wdata[1] = d;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        n_checks++;
        if ({bus_valid_w[1], bus_addr_w[1], bus_be_w[1], bus_wdata_w[1], bus_last_w[1], req_ready_w[1]} !==
            {1'b1, exp_addr[0], exp_be[0], exp_wd[0], 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bp beat0: valid=%b addr=%h be=%h wd=%h last=%b rdy=%b, required 1 %h %h %h 0 0",
                     bus_valid_w[1], bus_addr_w[1], bus_be_w[1], bus_wdata_w[1], bus_last_w[1],
                     req_ready_w[1], exp_addr[0], exp_be[0], exp_wd[0]);
        end
        sa = bus_addr_w[1]; sb = bus_be_w[1]; sw = bus_wdata_w[1]; sl = bus_last_w[1];
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus_valid_w[1], bus_addr_w[1], bus_be_w[1], bus_wdata_w[1], bus_last_w[1], req_ready_w[1]} !==
                {1'b1, sa, sb, sw, sl, 1'b0}) begin
                n_fail++;
                $display("FAIL bp hold cycle %0d: valid=%b addr=%h be=%h wd=%h last=%b rdy=%b, required stable beat0 and rdy=0",
                         c, bus_valid_w[1], bus_addr_w[1], bus_be_w[1], bus_wdata_w[1],
                         bus_last_w[1], req_ready_w[1]);
            end
        end
        bus_ready[1] = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus_valid_w[1], bus_addr_w[1], bus_be_w[1], bus_wdata_w[1], bus_last_w[1], req_ready_w[1]} !==
            {1'b1, exp_addr[1], exp_be[1], exp_wd[1], 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL bp beat1: valid=%b addr=%h be=%h wd=%h last=%b rdy=%b, required 1 %h %h %h 1 1",
                     bus_valid_w[1], bus_addr_w[1], bus_be_w[1], bus_wdata_w[1], bus_last_w[1],
                     req_ready_w[1], exp_addr[1], exp_be[1], exp_wd[1]);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus_valid_w[1], req_ready_w[1]} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp drain: valid=%b rdy=%b, required valid=0 rdy=1", bus_valid_w[1], req_ready_w[1]);
        end
        $display("backpressure split store held 5 cycles then drained");
    endtask

    task automatic test_wrap64();
        logic [63:0] d;
        d = {$urandom, $urandom};
        model(2, 32'hFFFFFFFD, 2'd3, d);
        xfer(2, 32'hFFFFFFFD, 2'd3, d, 1'b0);
        n_checks++;
        if ({obs_n, obs_be[0], obs_be[1], obs_addr[0], obs_addr[1]} !==
            {32'd2, 8'hE0, 8'h1F, 32'hFFFFFFF8, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap64 beats: n=%0d be0=%h be1=%h a0=%h a1=%h, required 2 e0 1f fffffff8 00000000",
                     obs_n, obs_be[0], obs_be[1], obs_addr[0], obs_addr[1]);
        end
        n_checks++;
        if ({obs_wd[0], obs_wd[1], obs_last[0], obs_last[1]} !== {exp_wd[0], exp_wd[1], 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap64 data: wd0=%h wd1=%h last=%b%b, required %h %h 01",
                     obs_wd[0], obs_wd[1], obs_last[0], obs_last[1], exp_wd[0], exp_wd[1]);
        end
        $display("dword wrap store be0=%h be1=%h a1=%h", obs_be[0], obs_be[1], obs_addr[1]);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a; logic [63:0] d;
        bus_ready[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; d = {$urandom, $urandom};
            model(2, a, 2'd0, d);
            req_valid[2] = 1'b1; req_addr[2] = a; req_size[2] = 2'd0; req_wdata[2] = d;
            @(posedge clk); #1;
            n_checks++;
            if ({bus_valid_w[2], bus_addr_w[2], bus_be_w[2], bus_wdata_w[2], bus_last_w[2], req_ready_w[2]} !==
                {1'b1, exp_addr[0], exp_be[0], exp_wd[0], 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL b2b %0d: valid=%b addr=%h be=%h wd=%h last=%b rdy=%b, required 1 %h %h %h 1 1",
                         i, bus_valid_w[2], bus_addr_w[2], bus_be_w[2], bus_wdata_w[2],
                         bus_last_w[2], req_ready_w[2], exp_addr[0], exp_be[0], exp_wd[0]);
            end
            $display("b2b byte store %0d addr=%h be=%h", i, a, bus_be_w[2]);
        end
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus_valid_w[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b drain: valid=%b, required 0", bus_valid_w[2]);
        end
    endtask

    task automatic test_reset_mid();
        int beats;
        bus_ready[1] = 1'b1;
        req_valid[1] = 1'b1; req_addr[1] = 32'h3006; req_size[1] = 2'd2; req_wdata[1] = 64'h55667788;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;     // beat 0 consumed, beat 1 pending
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_valid_w[1], bus_addr_w[1], bus_be_w[1], bus_wdata_w[1], bus_last_w[1],
             align_err_w[1], req_ready_w[1]} !== {1'b0, 32'h0, 8'h0, 64'h0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid reset: valid=%b addr=%h be=%h wd=%h last=%b err=%b rdy=%b, required all 0 and rdy=1",
                     bus_valid_w[1], bus_addr_w[1], bus_be_w[1], bus_wdata_w[1], bus_last_w[1],
                     align_err_w[1], req_ready_w[1]);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        beats = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus_valid_w[1]) beats++;
        end
        n_checks++;
        if (beats != 0 || req_ready_w[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL post reset: beat cycles=%0d rdy=%b, required 0 and rdy=1", beats, req_ready_w[1]);
        end
        $display("reset between beats dropped the store");
    endtask

    task automatic test_random();
        logic [31:0] a; logic [1:0] s; logic [63:0] d;
        for (int idx = 0; idx < 3; idx++) begin
            for (int n = 0; n < 30; n++) begin
                a = $urandom; s = 2'($urandom_range(0, 3)); d = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 0) a = a & ~((32'd1 << s) - 32'd1);
                model(idx, a, s, d);
                xfer(idx, a, s, d, 1'b1);
                n_checks++;
                if (obs_err != (exp_err ? 1 : 0) || obs_n != exp_n) begin
                    n_fail++;
                    $display("FAIL rnd inst%0d #%0d outcome: addr=%h size=%0d err=%0d beats=%0d, required err=%0d beats=%0d",
                             idx, n, a, s, obs_err, obs_n, exp_err, exp_n);
                end
                for (int b = 0; b < exp_n; b++) begin
                    n_checks++;
                    if ({obs_addr[b], obs_be[b], obs_wd[b], obs_last[b]} !==
                        {exp_addr[b], exp_be[b], exp_wd[b], exp_last[b]}) begin
                        n_fail++;
                        $display("FAIL rnd inst%0d #%0d beat%0d: addr=%h be=%h wd=%h last=%b, required %h %h %h %b",
                                 idx, n, b, obs_addr[b], obs_be[b], obs_wd[b], obs_last[b],
                                 exp_addr[b], exp_be[b], exp_wd[b], exp_last[b]);
                    end
                end
                $display("rnd inst%0d #%0d addr=%h size=%0d err=%0d beats=%0d",
                         idx, n, a, s, obs_err, obs_n);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_addr[i] = '0; req_size[i] = '0;
            req_wdata[i] = '0; bus_ready[i] = 1'b1;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_aligned();
        test_split();
        test_align_err();
        test_backpressure();
        test_wrap64();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
